turn_scheduler: RTL
===================

Name: turn_scheduler

Overview:
Sequences play for the chicken track game once the front-end control FSM has fixed the player count and asserted start. Owns per-player track positions and tail counts, rotates turns round-robin, applies card-flip results, detects captures, and declares the winner. Sits between the key/flip input logic and the display/LED datapath.

Parameters:
TRACK_LEN, 24, number of track tiles; must be a multiple of 12 so that 2, 3 and 4 player spacings are integers.
POS_W, 5, position width; must satisfy 2**POS_W >= TRACK_LEN.
TURN_TIMEOUT, 1024, cycles allowed in TURN_WAIT before an automatic miss (used only with TURN_TIMEOUT_EN).

Ports:
clk  in  1  system clock; the only clock.
rst  in  1  reset, asynchronous, active-high.
start  in  1  one-cycle pulse that begins a game; honoured only in IDLE or DONE.
num_players  in  3  player count, sampled when start is accepted; values below 2 clamp to 2, above 4 clamp to 4.
flip_valid  in  1  one-cycle pulse: a card flip result is present.
flip_match  in  1  qualified by flip_valid; 1 = card matches the next tile.
turn_active  out  1  high while the scheduler is waiting on cur_player's flip.
cur_player  out  2  index of the player whose turn it is.
cur_pos  out  POS_W  position of cur_player.
cur_tails  out  3  tail count of cur_player.
capture  out  1  one-cycle pulse when tails are taken.
timeout  out  1  one-cycle pulse on an automatic miss.
win  out  1  high in DONE.
winner  out  2  valid while win is high.
state  out  3  FSM state, for debug display.

Behaviour:
- Reset (async): state=IDLE. All outputs 0. All positions, tail counts and counters 0.
- States: IDLE=0, LOAD=1, TURN_WAIT=2, CHECK=3, NEXT=4, DONE=7.
- IDLE/DONE: on start, latch the clamped num_players and go to LOAD. In DONE, win and winner hold until start is accepted.
- LOAD (1 cycle): set pos[i] = i*TRACK_LEN/num_players for active i, tails[i]=1, cur_player=0. Next state is TURN_WAIT. turn_active rises 2 edges after the start edge.
- TURN_WAIT (turn_active=1):
  - flip_valid with flip_match=1: on the same edge, pos[cur] <= (pos[cur]==TRACK_LEN-1) ? 0 : pos[cur]+1, then go to CHECK.
  - flip_valid with flip_match=0: go to NEXT.
- CHECK (1 cycle):
  - Target = lowest-index active player other than cur with pos equal to pos[cur] and tails > 0.
  - If a target exists: tails[cur] += tails[target], tails[target] = 0, pulse capture.
  - If the resulting tails[cur] == num_players: winner=cur, go to DONE. Otherwise return to TURN_WAIT with the same player, who keeps the turn after a match.
- NEXT (1 cycle, turn_active=0): cur_player <= (cur_player == num_players-1) ? 0 : cur_player+1, then go to TURN_WAIT. Players with 0 tails still take turns.
- flip_valid outside TURN_WAIT is ignored, as is start outside IDLE/DONE.
- Tail total is invariant at num_players; capture transfers only a nonzero count.
- rst mid-game aborts immediately to IDLE with all state cleared.

Optional Feature:
TURN_TIMEOUT_EN.
- Defined: a counter clears on every entry to TURN_WAIT and increments each cycle there. When it reaches TURN_TIMEOUT-1 with no flip_valid, pulse timeout and go to NEXT (treated as a miss). A flip_valid on that same cycle wins over the timeout.
- Undefined: no counter is built, timeout is tied to 0, and TURN_WAIT waits indefinitely.

Decomposition:
- Shared package/header chicken_pkg holds state encodings, TRACK_LEN, POS_W, and the player-index width, shared with the front-end control FSM and display logic.
- One sub-module, turn_timer: counter with clear, enable and expire outputs, instantiated only under TURN_TIMEOUT_EN.

Test Plan:
- start with num_players=3 -> LOAD, then TURN_WAIT; positions 0/8/16, tails 1/1/1, cur_player=0, turn_active=1 on the 2nd edge after start.
- num_players=5 -> 4 players at 0/6/12/18. num_players=1 -> 2 players at 0/12.
- Player 0 in TURN_WAIT, flip miss -> NEXT with turn_active=0 for one cycle, then cur_player=1. With 3 players, a miss by player 2 -> cur_player=0.
- Player at pos 23, flip match -> cur_pos=0 and no capture; same player keeps the turn.
- 2 players at 0/12, player 0 makes 12 matches -> capture pulse on the 12th CHECK, tails 2/0, win=1, winner=0, state=7; later flip_valid is ignored; start restarts the game.
- Assert rst mid-CHECK -> state=0 and all outputs 0 asynchronously.
- With TURN_TIMEOUT_EN and TURN_TIMEOUT=16: 16 idle cycles in TURN_WAIT -> timeout pulse and cur_player advances. A flip at cycle 15 -> no timeout.

Source files
------------

// File: rtl/chicken_pkg.sv
// Shared definitions for the chicken track game: state codes,
// track geometry and the player-index width.
package chicken_pkg;

    localparam int TRACK_LEN = 24;
    localparam int POS_W     = 5;
    localparam int PLR_W     = 2;
    localparam int MAX_PLR   = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        TURN_WAIT = 3'd2,
        CHECK     = 3'd3,
        NEXT      = 3'd4,
        DONE      = 3'd7
    } state_t;

    function automatic logic [2:0] clamp_players(input logic [2:0] n);
        if (n < 3'd2)      return 3'd2;
        else if (n > 3'd4) return 3'd4;
        else               return n;
    endfunction

endpackage

// File: rtl/turn_timer.sv
// Turn watchdog: counts while enabled, flags the last allowed cycle.
// Built only when TURN_TIMEOUT_EN is defined.
module turn_timer #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && !expire)
            count <= count + 1'b1;
    end

    assign expire = enable && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/turn_scheduler.sv
// Turn sequencing, captures and win detection for the chicken track game.
// Optional turn watchdog enabled by defining TURN_TIMEOUT_EN.
module turn_scheduler #(
    parameter int TRACK_LEN    = chicken_pkg::TRACK_LEN,
    parameter int POS_W        = chicken_pkg::POS_W,
    parameter int TURN_TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       num_players,
    input  logic             flip_valid,
    input  logic             flip_match,
    output logic             turn_active,
    output logic [1:0]       cur_player,
    output logic [POS_W-1:0] cur_pos,
    output logic [2:0]       cur_tails,
    output logic             capture,
    output logic             timeout,
    output logic             win,
    output logic [1:0]       winner,
    output logic [2:0]       state
);

    import chicken_pkg::*;

    localparam logic [POS_W-1:0] LAST = POS_W'(TRACK_LEN - 1);

    state_t           st, st_n;
    logic [2:0]       num;
    logic [POS_W-1:0] pos   [MAX_PLR];
    logic [2:0]       tails [MAX_PLR];
    logic [1:0]       cur;
    logic [1:0]       win_q;

    logic             hit;
    logic [1:0]       tgt;
    logic [2:0]       sum;
    logic [POS_W-1:0] sp;
    logic             to_exp;

    always_comb begin
        unique case (num)
            3'd3:    sp = POS_W'(TRACK_LEN / 3);
            3'd4:    sp = POS_W'(TRACK_LEN / 4);
            default: sp = POS_W'(TRACK_LEN / 2);
        endcase
    end

    // Lowest-index opponent sharing the mover's tile and still holding tails.
    always_comb begin
        hit = 1'b0;
        tgt = '0;
        for (int i = 0; i < MAX_PLR; i++) begin
            if (!hit && 2'(i) != cur && 3'(i) < num &&
                pos[i] == pos[cur] && tails[i] != 3'd0) begin
                hit = 1'b1;
                tgt = 2'(i);
            end
        end
        sum = tails[cur] + (hit ? tails[tgt] : 3'd0);
    end

`ifdef TURN_TIMEOUT_EN
    turn_timer #(
        .LIMIT (TURN_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (st != TURN_WAIT),
        .enable (st == TURN_WAIT),
        .expire (to_exp)
    );
`else
    logic unused_cfg;
    assign unused_cfg = ^32'(TURN_TIMEOUT);
    assign to_exp     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            st <= IDLE;
        else
            st <= st_n;
    end

    always_comb begin
        st_n = st;
        unique case (st)
            IDLE, DONE: if (start) st_n = LOAD;
            LOAD:       st_n = TURN_WAIT;
            TURN_WAIT: begin
                if (flip_valid)
                    st_n = flip_match ? CHECK : NEXT;
                else if (to_exp)
                    st_n = NEXT;
            end
            CHECK:      st_n = (sum == num) ? DONE : TURN_WAIT;
            NEXT:       st_n = TURN_WAIT;
            default:    st_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num   <= '0;
            cur   <= '0;
            win_q <= '0;
            for (int i = 0; i < MAX_PLR; i++) begin
                pos[i]   <= '0;
                tails[i] <= '0;
            end
        end else begin
            unique case (st)
                IDLE, DONE: begin
                    if (start) num <= clamp_players(num_players);
                end
                LOAD: begin
                    cur <= '0;
                    for (int i = 0; i < MAX_PLR; i++) begin
                        pos[i]   <= (3'(i) < num) ? POS_W'(i) * sp : '0;
                        tails[i] <= (3'(i) < num) ? 3'd1 : 3'd0;
                    end
                end
                TURN_WAIT: begin
                    if (flip_valid && flip_match)
                        pos[cur] <= (pos[cur] == LAST) ? '0 : pos[cur] + 1'b1;
                end
                CHECK: begin
                    if (hit) begin
                        tails[cur] <= sum;
                        tails[tgt] <= 3'd0;
                    end
                    if (sum == num) win_q <= cur;
                end
                NEXT: begin
                    cur <= ({1'b0, cur} == num - 3'd1) ? 2'd0 : cur + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign turn_active = (st == TURN_WAIT);
    assign cur_player  = cur;
    assign cur_pos     = pos[cur];
    assign cur_tails   = tails[cur];
    assign capture     = (st == CHECK) && hit;
    assign timeout     = (st == TURN_WAIT) && to_exp && !flip_valid;
    assign win         = (st == DONE);
    assign winner      = win_q;
    assign state       = st;

endmodule
